// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit (shift-add multiplier, restoring divider) with valid/ready handshake and flush
module mdu_iter #(
  parameter int XLEN = 32,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [CNTW-1:0] cnt;
  logic [2*XLEN-1:0] acc, acc_nx, prod;
  logic [XLEN-1:0] opb, abs_a, abs_b, quo, rem, fin, spec_res;
  logic [XLEN:0] sum, rsh, diff;
  logic [2:0] f3;
  logic neg, rneg, sgn_a, sgn_b, sa, sb, div0, ovf;
  always_comb begin
    sgn_a = funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
    sgn_b = funct3 inside {3'b001, 3'b100, 3'b110};
    sa = sgn_a & rs1[XLEN-1];
    sb = sgn_b & rs2[XLEN-1];
    abs_a = sa ? -rs1 : rs1;
    abs_b = sb ? -rs2 : rs2;
    div0 = funct3[2] && rs2 == '0;
    ovf = funct3[2] && !funct3[0] && rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1;
    spec_res = div0 ? (funct3[1] ? rs1 : '1) : (funct3[1] ? '0 : rs1);
    // acc holds {partial product high, multiplier} for multiply and {remainder, dividend/quotient} for divide
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? opb : {XLEN{1'b0}}};
    rsh = acc[2*XLEN-1:XLEN-1];
    diff = rsh - {1'b0, opb};
    acc_nx = f3[2] ? {diff[XLEN] ? rsh[XLEN-1:0] : diff[XLEN-1:0], acc[XLEN-2:0], ~diff[XLEN]}
                   : {sum, acc[XLEN-1:1]};
    prod = neg ? -acc_nx : acc_nx;
    quo = neg ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    rem = rneg ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
    fin = f3[2] ? (f3[1] ? rem : quo) : (f3[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      opb <= '0;
      f3 <= '0;
      neg <= 1'b0;
      rneg <= 1'b0;
      result <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          f3 <= funct3;
          neg <= sa ^ sb;
          rneg <= sa;
          opb <= funct3[2] ? abs_b : abs_a;
          acc <= {{XLEN{1'b0}}, funct3[2] ? abs_a : abs_b};
          in_ready <= 1'b0;
          busy <= 1'b1;
          if (div0 || ovf) begin
            result <= spec_res;
            out_valid <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= CNTW'(XLEN);
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CNTW'(1)) begin
            result <= fin;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          in_ready <= 1'b1;
          out_valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized and directed checks of mdu_iter (XLEN=32 and XLEN=16) against an arithmetic reference model
module tb_mdu_iter;
  logic clk = 0, rst = 1, flush = 0, iv = 0, ordy = 0, use16 = 0;
  logic [2:0] f = 0;
  logic [31:0] a = 0, b = 0;
  logic ir32, ov32, busy32, ir16, ov16, busy16;
  logic [31:0] res32;
  logic [15:0] res16;
  logic ir_s, ov_s, busy_s;
  logic [31:0] res_s;
  int n_chk = 0, n_ok = 0;
  always #5 clk = ~clk;
  mdu_iter #(.XLEN(32)) dut (.clk(clk), .rst(rst), .flush(flush), .in_valid(iv & !use16), .in_ready(ir32),
    .funct3(f), .rs1(a), .rs2(b), .out_valid(ov32), .out_ready(ordy), .result(res32), .busy(busy32));
  mdu_iter #(.XLEN(16)) dut16 (.clk(clk), .rst(rst), .flush(flush), .in_valid(iv & use16), .in_ready(ir16),
    .funct3(f), .rs1(a[15:0]), .rs2(b[15:0]), .out_valid(ov16), .out_ready(ordy), .result(res16), .busy(busy16));
  assign ir_s = use16 ? ir16 : ir32;
  assign ov_s = use16 ? ov16 : ov32;
  assign busy_s = use16 ? busy16 : busy32;
  assign res_s = use16 ? {16'h0, res16} : res32;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_op(input int w, input logic [2:0] fn, input logic [31:0] x, input logic [31:0] y);
    longint m = (longint'(1) << w) - 1;
    longint xu = longint'(x) & m, yu = longint'(y) & m;
    longint xs = ((xu >> (w - 1)) & 1) != 0 ? xu - (m + 1) : xu;
    longint ys = ((yu >> (w - 1)) & 1) != 0 ? yu - (m + 1) : yu;
    logic ovfl = xs == -((m + 1) >> 1) && ys == -1;
    longint p;
    case (fn)
      3'd0: p = xs * ys;
      3'd1: p = (xs * ys) >> w;
      3'd2: p = (xs * yu) >> w;
      3'd3: p = (xu * yu) >> w;
      3'd4: p = yu == 0 ? m : ovfl ? xu : xs / ys;
      3'd5: p = yu == 0 ? m : xu / yu;
      3'd6: p = yu == 0 ? xu : ovfl ? 0 : xs % ys;
      default: p = yu == 0 ? xu : xu % yu;
    endcase
    return 32'(p & m);
  endfunction

  task automatic do_op(input logic [2:0] fn, input logic [31:0] x, input logic [31:0] y, input int hold);
    int w = use16 ? 16 : 32;
    logic [31:0] m = use16 ? 32'h0000ffff : 32'hffffffff;
    logic [31:0] xm = x & m, ym = y & m, exp = ref_op(w, fn, x, y);
    logic spec = fn[2] && (ym == 0 || (!fn[0] && xm == ((m >> 1) + 1) && ym == m));
    int lat = 1;
    string t = $sformatf("w%0d f%0d %h,%h", w, fn, xm, ym);
    @(posedge clk) #1;
    chk({t, " in_ready"}, 32'(ir_s), 1);
    iv = 1; f = fn; a = xm; b = ym;
    @(posedge clk) #1;
    iv = 0; f = 3'($urandom); a = $urandom; b = $urandom;
    chk({t, " busy"}, 32'(busy_s), 1);
    while (!ov_s && lat < 100) begin
      @(posedge clk) #1;
      lat++;
    end
    chk({t, " latency"}, lat, spec ? 1 : w + 1);
    chk({t, " result"}, res_s, exp);
    repeat (hold) begin
      @(posedge clk) #1;
      chk({t, " hold result"}, res_s, exp);
      chk({t, " hold valid"}, 32'(ov_s), 1);
      chk({t, " hold in_ready"}, 32'(ir_s), 0);
    end
    ordy = 1;
    @(posedge clk) #1;
    ordy = 0;
    chk({t, " taken valid"}, 32'(ov_s), 0);
    chk({t, " taken in_ready"}, 32'(ir_s), 1);
  endtask

  task automatic abort(input logic by_rst);
    string t = by_rst ? "rst abort" : "flush abort";
    @(posedge clk) #1;
    iv = 1; f = 3'd0; a = $urandom; b = $urandom;
    @(posedge clk) #1;
    iv = 0;
    repeat (10) @(posedge clk);
    #1;
    if (by_rst) rst = 1; else flush = 1;
    @(posedge clk) #1;
    rst = 0; flush = 0;
    chk({t, " in_ready"}, 32'(ir_s), 1);
    chk({t, " busy"}, 32'(busy_s), 0);
    if (by_rst) chk({t, " result"}, res_s, 0);
    repeat (40) begin
      chk({t, " valid"}, 32'(ov_s), 0);
      @(posedge clk) #1;
    end
    flush = 1; iv = 1;
    @(posedge clk) #1;
    flush = 0; iv = 0;
    chk({t, " flush+valid no accept"}, 32'(busy_s), 0);
    do_op(3'd0, 7, 6, 0);
  endtask

  function automatic logic [31:0] pick();
    int s = $urandom_range(0, 7);
    return s == 0 ? 0 : s == 1 ? 32'hffffffff : s == 2 ? (use16 ? 32'h8000 : 32'h80000000) : s == 3 ? $urandom_range(0, 9) : $urandom;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset in_ready32", 32'(ir32), 1);
    chk("reset valid32", 32'(ov32), 0);
    chk("reset busy32", 32'(busy32), 0);
    chk("reset result32", res32, 0);
    chk("reset in_ready16", 32'(ir16), 1);
    chk("reset result16", {16'h0, res16}, 0);
    do_op(3'd0, 7, 6, 5);
    do_op(3'd1, 32'hfffffffe, 3, 0);
    do_op(3'd3, 32'hfffffffe, 3, 0);
    do_op(3'd2, 32'hffffffff, 32'hffffffff, 0);
    do_op(3'd4, 32'hfffffff9, 2, 0);
    do_op(3'd6, 32'hfffffff9, 2, 0);
    do_op(3'd5, 32'hfffffff9, 2, 0);
    do_op(3'd7, 32'hfffffff9, 2, 0);
    do_op(3'd5, 7, 0, 2);
    do_op(3'd6, 7, 0, 0);
    do_op(3'd4, 32'h80000000, 32'hffffffff, 1);
    do_op(3'd6, 32'h80000000, 32'hffffffff, 0);
    abort(0);
    abort(1);
    for (int i = 0; i < 60; i++) do_op(3'($urandom), pick(), pick(), $urandom_range(0, 2));
    use16 = 1;
    do_op(3'd0, 7, 6, 2);
    do_op(3'd4, 32'hfff9, 2, 0);
    do_op(3'd6, 32'h8000, 32'hffff, 0);
    abort(0);
    for (int i = 0; i < 60; i++) do_op(3'($urandom), pick(), pick(), $urandom_range(0, 2));
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
